// File: rtl/mem_pkg.sv
// Shared types and byte-lane helpers for the MEM pipeline stage.
package mem_pkg;

    typedef enum logic [1:0] {
        MS_B = 2'd0,
        MS_H = 2'd1,
        MS_W = 2'd2,
        MS_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int STRB_W = 8;

    function automatic logic [STRB_W-1:0] size_mask(input mem_size_e size);
        logic [STRB_W-1:0] m;
        case (size)
            MS_B:    m = 8'h01;
            MS_H:    m = 8'h03;
            MS_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Byte offset rounded down to the natural alignment of the access size.
    function automatic logic [2:0] align_offset(input logic [2:0] off, input mem_size_e size);
        logic [2:0] a;
        case (size)
            MS_B:    a = off;
            MS_H:    a = {off[2:1], 1'b0};
            MS_W:    a = {off[2], 2'b00};
            default: a = 3'b000;
        endcase
        return a;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] off, input mem_size_e size);
        return off != align_offset(off, size);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store data/strobes onto the 8-byte bus and
// load data extraction with sign or zero extension.
module mem_align
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  mem_size_e       size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] load_result
);

    logic [5:0]             shamt;
    logic [XLEN-1:0]        shifted;
    logic signed [7:0]      sb;
    logic signed [15:0]     sh;
    logic signed [31:0]     sw;
    logic signed [XLEN-1:0] ext_s;
    logic [XLEN-1:0]        ext_u;

    assign shamt   = {offset, 3'b000};
    assign wdata   = store_data << shamt;
    assign wstrb   = size_mask(size) << offset;
    assign shifted = rdata >> shamt;

    assign sb = shifted[7:0];
    assign sh = shifted[15:0];
    assign sw = shifted[31:0];

    always_comb begin
        ext_s = $signed(shifted);
        ext_u = shifted;
        case (size)
            MS_B: begin
                ext_s = XLEN'(sb);
                ext_u = XLEN'(shifted[7:0]);
            end
            MS_H: begin
                ext_s = XLEN'(sh);
                ext_u = XLEN'(shifted[15:0]);
            end
            MS_W: begin
                ext_s = XLEN'(sw);
                ext_u = XLEN'(shifted[31:0]);
            end
            default: begin
                ext_s = $signed(shifted);
                ext_u = shifted;
            end
        endcase
        load_result = is_unsigned ? ext_u : $unsigned(ext_s);
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a request/response data port and registers MEM/WB.
// Build macro MEMSTAGE_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them down.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64,
    parameter int REG_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EXMEM_ready,
    input  logic [XLEN-1:0]   exmm_aluresult,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic              mem_active,
    input  logic              load,
    input  logic [XLEN-1:0]   store_data,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    output logic              mem_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              MEMWB_ready,
    output logic [XLEN-1:0]   memwb_result,
    output logic [REG_W-1:0]  memwb_dest_reg,
    output logic              misalign_trap
);

    state_e            state, state_nxt;
    mem_size_e         size_in;
    logic [ADDR_W-1:0] addr_in;
    logic              misaligned;
    logic              accept;
    logic              retire;

    logic [ADDR_W-1:0] addr_p1;
    mem_size_e         size_p1;
    logic              unsigned_p1;
    logic              load_p1;
    logic [REG_W-1:0]  dest_p1;
    logic [XLEN-1:0]   sdata_p1;

    logic [XLEN-1:0]   align_wdata;
    logic [7:0]        align_wstrb;
    logic [XLEN-1:0]   load_result;

    assign size_in = mem_size_e'(mem_size);

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    logic trap_p1;

    assign addr_in    = exmm_aluresult[ADDR_W-1:0];
    assign misaligned = mem_active && is_misaligned(exmm_aluresult[2:0], size_in);

    always_ff @(posedge clk) begin
        if (!reset) begin
            trap_p1 <= 1'b0;
        end else begin
            trap_p1 <= accept && misaligned;
        end
    end

    assign misalign_trap = trap_p1;
`else
    // Misaligned addresses silently round down to the access size.
    assign addr_in       = {exmm_aluresult[ADDR_W-1:3], align_offset(exmm_aluresult[2:0], size_in)};
    assign misaligned    = 1'b0;
    assign misalign_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (EXMEM_ready) begin
                    accept = 1'b1;
                    if (mem_active && !misaligned) begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        state_nxt = IDLE;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                    retire    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p1: access fields captured at accept, stable for the whole transaction
    always_ff @(posedge clk) begin
        if (accept && mem_active) begin
            addr_p1     <= addr_in;
            size_p1     <= size_in;
            unsigned_p1 <= mem_unsigned;
            load_p1     <= load;
            dest_p1     <= dest_reg;
            sdata_p1    <= store_data;
        end
    end

    mem_align #(
        .XLEN (XLEN)
    ) u_align (
        .store_data  (sdata_p1),
        .rdata       (mem_rdata),
        .offset      (addr_p1[2:0]),
        .size        (size_p1),
        .is_unsigned (unsigned_p1),
        .wdata       (align_wdata),
        .wstrb       (align_wstrb),
        .load_result (load_result)
    );

    assign mem_busy  = (state != IDLE);
    assign mem_req   = (state == REQ);
    assign mem_addr  = mem_req ? {addr_p1[ADDR_W-1:3], 3'b000} : '0;
    assign mem_we    = mem_req && !load_p1;
    assign mem_wdata = mem_we ? align_wdata : '0;
    assign mem_wstrb = mem_we ? align_wstrb : '0;

    // p2: MEM/WB bundle; result and dest hold between retire pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            MEMWB_ready    <= 1'b0;
            memwb_result   <= '0;
            memwb_dest_reg <= '0;
        end else begin
            MEMWB_ready <= (accept && (!mem_active || misaligned)) || retire;
            if (accept && !mem_active) begin
                memwb_result   <= exmm_aluresult;
                memwb_dest_reg <= dest_reg;
            end else if (accept && misaligned) begin
                memwb_result   <= '0;
                memwb_dest_reg <= '0;
            end else if (retire) begin
                memwb_result   <= load_p1 ? load_result : '0;
                memwb_dest_reg <= load_p1 ? dest_p1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against a byte-level model.
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        EXMEM_ready = 1'b0;
    logic [63:0] exmm_aluresult = '0;
    logic [5:0]  dest_reg = '0;
    logic        mem_active = 1'b0;
    logic        load = 1'b0;
    logic [63:0] store_data = '0;
    logic [1:0]  mem_size = '0;
    logic        mem_unsigned = 1'b0;
    logic        mem_busy;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        MEMWB_ready;
    logic [63:0] memwb_result;
    logic [5:0]  memwb_dest_reg;
    logic        misalign_trap;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] last_res = '0;
    logic [5:0]  last_dest = '0;
    bit          res_known = 1'b1;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(64), .ADDR_W(64), .REG_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .EXMEM_ready    (EXMEM_ready),
        .exmm_aluresult (exmm_aluresult),
        .dest_reg       (dest_reg),
        .mem_active     (mem_active),
        .load           (load),
        .store_data     (store_data),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .mem_busy       (mem_busy),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .MEMWB_ready    (MEMWB_ready),
        .memwb_result   (memwb_result),
        .memwb_dest_reg (memwb_dest_reg),
        .misalign_trap  (misalign_trap)
    );

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // EX keeps presenting arbitrary bundles while the stage is busy; none may be taken.
    task automatic drive_garbage();
        EXMEM_ready    = 1'($urandom_range(0, 1));
        mem_active     = 1'($urandom_range(0, 1));
        load           = 1'($urandom_range(0, 1));
        exmm_aluresult = rand64();
        dest_reg       = 6'($urandom);
        store_data     = rand64();
        mem_size       = 2'($urandom);
        mem_unsigned   = 1'($urandom_range(0, 1));
    endtask

    task automatic run_alu(input logic [63:0] res, input logic [5:0] dst);
        vectors++;
        if (mem_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_accept_idle: mem_busy=%b required 0", mem_busy);
        end
        EXMEM_ready    = 1'b1;
        mem_active     = 1'b0;
        load           = 1'($urandom_range(0, 1));
        exmm_aluresult = res;
        dest_reg       = dst;
        store_data     = rand64();
        mem_size       = 2'($urandom);
        tick();
        EXMEM_ready = 1'b0;
        vectors++;
        if ({MEMWB_ready, memwb_result, memwb_dest_reg, mem_req, misalign_trap} !== {1'b1, res, dst, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL alu_retire: rdy/res/dest/req/trap got %b/%h/%0d/%b/%b required 1/%h/%0d/0/0",
                     MEMWB_ready, memwb_result, memwb_dest_reg, mem_req, misalign_trap, res, dst);
        end
        last_res  = res;
        last_dest = dst;
        res_known = 1'b1;
    endtask

    task automatic run_mem(input bit ld, input logic [63:0] addr, input int sz, input bit uns,
                           input logic [63:0] sdata, input logic [5:0] dst,
                           input logic [63:0] rdata, input int gdly, input int rdly);
        int          nb;
        int          off;
        bit          mis;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [63:0] exp_res;
        logic [7:0]  exp_wstrb;
        nb  = 1 << sz;
        off = int'(addr[2:0]);
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
        mis = (off % nb) != 0;
`else
        mis = 1'b0;
        off = off - (off % nb);
`endif
        exp_addr  = addr & ~64'h7;
        exp_wdata = '0;
        exp_wstrb = '0;
        exp_res   = '0;
        if (!mis) begin
            for (int j = off; j < 8; j++) exp_wdata[j*8 +: 8] = sdata[(j-off)*8 +: 8];
            for (int j = 0; j < nb; j++) begin
                exp_wstrb[off+j]  = 1'b1;
                exp_res[j*8 +: 8] = rdata[(off+j)*8 +: 8];
            end
            if (!uns && exp_res[nb*8-1]) begin
                for (int j = nb; j < 8; j++) exp_res[j*8 +: 8] = 8'hFF;
            end
        end

        vectors++;
        if (mem_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_accept_idle: mem_busy=%b required 0", mem_busy);
        end
        EXMEM_ready    = 1'b1;
        mem_active     = 1'b1;
        load           = ld;
        exmm_aluresult = addr;
        mem_size       = sz[1:0];
        mem_unsigned   = uns;
        store_data     = sdata;
        dest_reg       = dst;
        tick();
        EXMEM_ready = 1'b0;

        if (mis) begin
            vectors++;
            if ({mem_req, MEMWB_ready, misalign_trap, memwb_dest_reg, mem_busy} !== {1'b0, 1'b1, 1'b1, 6'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL trap_pulse: req/rdy/trap/dest/busy got %b/%b/%b/%0d/%b required 0/1/1/0/0",
                         mem_req, MEMWB_ready, misalign_trap, memwb_dest_reg, mem_busy);
            end
            tick();
            vectors++;
            if ({mem_req, MEMWB_ready, misalign_trap} !== 3'b000) begin
                miscompares++;
                $display("FAIL trap_after: req/rdy/trap got %b/%b/%b required 0/0/0", mem_req, MEMWB_ready, misalign_trap);
            end
            last_dest = '0;
            res_known = 1'b0;
            return;
        end

        vectors++;
        if ({mem_req, mem_busy, MEMWB_ready, mem_addr, mem_we} !== {1'b1, 1'b1, 1'b0, exp_addr, !ld}) begin
            miscompares++;
            $display("FAIL req_issue: req/busy/rdy/addr/we got %b/%b/%b/%h/%b required 1/1/0/%h/%b",
                     mem_req, mem_busy, MEMWB_ready, mem_addr, mem_we, exp_addr, !ld);
        end
        if (!ld) begin
            vectors++;
            if ({mem_wdata, mem_wstrb} !== {exp_wdata, exp_wstrb}) begin
                miscompares++;
                $display("FAIL store_lanes: wdata/wstrb got %h/%h required %h/%h", mem_wdata, mem_wstrb, exp_wdata, exp_wstrb);
            end
        end
        for (int c = 0; c < gdly; c++) begin
            drive_garbage();
            tick();
            vectors++;
            if ({mem_req, mem_busy, MEMWB_ready, mem_addr} !== {1'b1, 1'b1, 1'b0, exp_addr}) begin
                miscompares++;
                $display("FAIL req_hold: req/busy/rdy/addr got %b/%b/%b/%h required 1/1/0/%h",
                         mem_req, mem_busy, MEMWB_ready, mem_addr, exp_addr);
            end
        end
        drive_garbage();
        mem_gnt    = 1'b1;
        mem_rvalid = (rdly == 0);
        mem_rdata  = (rdly == 0) ? rdata : rand64();
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (rdly > 0) begin
            for (int c = 0; c < rdly; c++) begin
                vectors++;
                if ({mem_req, mem_busy, MEMWB_ready} !== 3'b010) begin
                    miscompares++;
                    $display("FAIL resp_wait: req/busy/rdy got %b/%b/%b required 0/1/0", mem_req, mem_busy, MEMWB_ready);
                end
                drive_garbage();
                mem_rvalid = (c == rdly - 1);
                mem_rdata  = (c == rdly - 1) ? rdata : rand64();
                tick();
                mem_rvalid = 1'b0;
            end
        end
        EXMEM_ready = 1'b0;
        mem_rdata   = rand64();
        vectors++;
        if ({MEMWB_ready, mem_busy, mem_req, misalign_trap, memwb_result, memwb_dest_reg} !==
            {1'b1, 1'b0, 1'b0, 1'b0, (ld ? exp_res : 64'h0), (ld ? dst : 6'd0)}) begin
            miscompares++;
            $display("FAIL mem_retire: rdy/busy/req/trap/res/dest got %b/%b/%b/%b/%h/%0d required 1/0/0/0/%h/%0d",
                     MEMWB_ready, mem_busy, mem_req, misalign_trap, memwb_result, memwb_dest_reg,
                     (ld ? exp_res : 64'h0), (ld ? dst : 6'd0));
        end
        last_res  = ld ? exp_res : 64'h0;
        last_dest = ld ? dst : 6'd0;
        res_known = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({mem_busy, mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb, MEMWB_ready, memwb_result,
             memwb_dest_reg, misalign_trap} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy/req/addr/we/wdata/wstrb/rdy/res/dest/trap got %b/%b/%h/%b/%h/%h/%b/%h/%0d/%b required all 0",
                     mem_busy, mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb, MEMWB_ready, memwb_result,
                     memwb_dest_reg, misalign_trap);
        end
        reset     = 1'b1;
        last_res  = '0;
        last_dest = '0;
        res_known = 1'b1;
    endtask

    task automatic test_alu();
        run_alu(64'h1234, 6'd5);
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({MEMWB_ready, memwb_result, memwb_dest_reg, mem_req} !== {1'b0, 64'h1234, 6'd5, 1'b0}) begin
                miscompares++;
                $display("FAIL alu_hold: rdy/res/dest/req got %b/%h/%0d/%b required 0/1234/5/0",
                         MEMWB_ready, memwb_result, memwb_dest_reg, mem_req);
            end
        end
        run_alu(64'hDEAD_BEEF_0000_0001, 6'd0);
        tick();
    endtask

    task automatic test_lb_sign();
        run_mem(1'b1, 64'h1003, 0, 1'b0, rand64(), 6'd9, 64'h0000_0000_8000_0000, 0, 0);
        vectors++;
        if (memwb_result !== 64'hFFFF_FFFF_FFFF_FF80) begin
            miscompares++;
            $display("FAIL lb_sign_const: result got %h required ffffffffffffff80", memwb_result);
        end
        tick();
    endtask

    task automatic test_sh_wait();
        run_mem(1'b0, 64'h2006, 1, 1'b0, 64'h0000_0000_0000_ABCD, 6'd7, rand64(), 3, 2);
        tick();
        vectors++;
        if ({MEMWB_ready, memwb_dest_reg} !== {1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL sh_single_retire: rdy/dest got %b/%0d required 0/0", MEMWB_ready, memwb_dest_reg);
        end
    endtask

    task automatic test_lwu_back_to_back();
        run_mem(1'b1, 64'hC, 2, 1'b1, rand64(), 6'd12, 64'hF000_0001_1234_5678, 1, 0);
        vectors++;
        if (memwb_result !== 64'h0000_0000_F000_0001) begin
            miscompares++;
            $display("FAIL lwu_const: result got %h required 00000000f0000001", memwb_result);
        end
        run_mem(1'b1, 64'h8, 2, 1'b1, rand64(), 6'd13, 64'h1234_5678_F000_0001, 0, 0);
        run_mem(1'b0, 64'h10, 3, 1'b0, rand64(), 6'd14, rand64(), 0, 1);
        run_alu(rand64(), 6'd15);
        run_mem(1'b1, 64'h21, 0, 1'b1, rand64(), 6'd16, rand64(), 2, 0);
        tick();
    endtask

    task automatic test_reset_mid_resp();
        EXMEM_ready    = 1'b1;
        mem_active     = 1'b1;
        load           = 1'b1;
        exmm_aluresult = 64'h3000;
        mem_size       = 2'd3;
        mem_unsigned   = 1'b0;
        dest_reg       = 6'd11;
        tick();
        EXMEM_ready = 1'b0;
        mem_gnt     = 1'b1;
        tick();
        mem_gnt = 1'b0;
        vectors++;
        if ({mem_busy, mem_req} !== 2'b10) begin
            miscompares++;
            $display("FAIL resp_before_reset: busy/req got %b/%b required 1/0", mem_busy, mem_req);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if ({mem_busy, mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb, MEMWB_ready, memwb_result,
             memwb_dest_reg, misalign_trap} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_resp: busy/req/rdy/res/dest got %b/%b/%b/%h/%0d required all 0",
                     mem_busy, mem_req, MEMWB_ready, memwb_result, memwb_dest_reg);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rand64();
        tick();
        mem_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if ({MEMWB_ready, mem_busy, mem_req, memwb_result, memwb_dest_reg} !== '0) begin
                miscompares++;
                $display("FAIL stray_rvalid: rdy/busy/req/res/dest got %b/%b/%b/%h/%0d required all 0",
                         MEMWB_ready, mem_busy, mem_req, memwb_result, memwb_dest_reg);
            end
            tick();
        end
        run_alu(rand64(), 6'd21);
        tick();
    endtask

    task automatic test_misalign();
        run_mem(1'b1, 64'h1002, 2, 1'b0, rand64(), 6'd3, 64'h0123_4567_89AB_CDEF, 0, 0);
        run_mem(1'b0, 64'h1007, 1, 1'b0, 64'h0000_0000_0000_5AA5, 6'd4, rand64(), 1, 1);
        run_mem(1'b1, 64'h4005, 3, 1'b0, rand64(), 6'd8, rand64(), 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_alu(rand64(), 6'($urandom));
            end else begin
                run_mem(1'($urandom_range(0, 1)), rand64(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        rand64(), 6'($urandom), rand64(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
            repeat ($urandom_range(0, 2)) begin
                tick();
                vectors++;
                if (MEMWB_ready !== 1'b0 || memwb_dest_reg !== last_dest || (res_known && memwb_result !== last_res)) begin
                    miscompares++;
                    $display("FAIL idle_hold: rdy/res/dest got %b/%h/%0d required 0/%h/%0d",
                             MEMWB_ready, memwb_result, memwb_dest_reg, last_res, last_dest);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_sign();
        test_sh_wait();
        test_lwu_back_to_back();
        test_reset_mid_resp();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end

endmodule
